// File: rtl/piradip_axi4_rd_arb.sv
// piradip_axi4_rd_arb: round-robin arbiter sharing one AXI4 read master port among NREQ
// requesters. Only one burst is in flight; the grant is held from AR acceptance through RLAST.
// Optional define PIRADIP_AXI4_RD_ARB_4K_CHECK_EN: INCR bursts crossing a 4 KB boundary and
// reserved burst types are answered locally with SLVERR beats instead of going downstream.
module piradip_axi4_rd_arb #(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NREQ-1:0]            s_arvalid,
  output logic [NREQ-1:0]            s_arready,
  input  logic [NREQ*ADDR_WIDTH-1:0] s_araddr,
  input  logic [NREQ*8-1:0]          s_arlen,
  input  logic [NREQ*3-1:0]          s_arsize,
  input  logic [NREQ*2-1:0]          s_arburst,
  input  logic [NREQ*3-1:0]          s_arprot,
  input  logic [NREQ*4-1:0]          s_arcache,
  output logic [NREQ-1:0]            s_rvalid,
  input  logic [NREQ-1:0]            s_rready,
  output logic [DATA_WIDTH-1:0]      s_rdata,
  output logic [1:0]                 s_rresp,
  output logic                       s_rlast,
  output logic                       m_arvalid,
  input  logic                       m_arready,
  output logic [ADDR_WIDTH-1:0]      m_araddr,
  output logic [7:0]                 m_arlen,
  output logic [2:0]                 m_arsize,
  output logic [1:0]                 m_arburst,
  output logic [2:0]                 m_arprot,
  output logic [3:0]                 m_arcache,
  output logic                       m_arlock,
  output logic [3:0]                 m_arqos,
  output logic [3:0]                 m_arregion,
  input  logic                       m_rvalid,
  output logic                       m_rready,
  input  logic [DATA_WIDTH-1:0]      m_rdata,
  input  logic [1:0]                 m_rresp,
  input  logic                       m_rlast
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [PW-1:0]         ptr;
  logic [PW-1:0]         gnt;
  logic                  win_valid;
  logic [PW-1:0]         win_idx;
  logic                  accept;
  logic                  reject;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [7:0]            sel_len;
  logic [2:0]            sel_size;
  logic [1:0]            sel_burst;
  logic [2:0]            sel_prot;
  logic [3:0]            sel_cache;

  // Requester index base+off, wrapped modulo NREQ
  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // Winner: first valid requester at or after ptr; descending scan lets the nearest one win
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (s_arvalid[rr_idx(ptr, unsigned'(k))]) begin
        win_valid = 1'b1;
        win_idx   = rr_idx(ptr, unsigned'(k));
      end
    end
  end

  // Mux the winner's AR payload out of the packed request buses
  always_comb begin
    sel_addr  = '0;
    sel_len   = '0;
    sel_size  = '0;
    sel_burst = '0;
    sel_prot  = '0;
    sel_cache = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (win_idx == PW'(i)) begin
        sel_addr  = s_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len   = s_arlen[i*8 +: 8];
        sel_size  = s_arsize[i*3 +: 3];
        sel_burst = s_arburst[i*2 +: 2];
        sel_prot  = s_arprot[i*3 +: 3];
        sel_cache = s_arcache[i*4 +: 4];
      end
    end
  end

  assign accept = (state == ST_IDLE) && win_valid;

`ifdef PIRADIP_AXI4_RD_ARB_4K_CHECK_EN
  localparam int unsigned CW = 24;
  logic [CW-1:0] span_end;
  logic [7:0]    cnt;

  // Byte offset just past the burst; wide enough that no term is truncated
  always_comb begin
    span_end = CW'(sel_addr[11:0]) + (CW'({1'b0, sel_len} + 9'd1) << sel_size);
    reject   = ((sel_burst == 2'b01) && (span_end > CW'(4096))) || (sel_burst == 2'b11);
  end

  // Remaining local error beats after the current one
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= sel_len;
    end else if ((state == ST_ERR) && s_rready[gnt] && (cnt != 8'd0)) begin
      cnt <= cnt - 8'd1;
    end
  end
`else
  assign reject = 1'b0;
`endif

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Grant, rotation pointer and downstream AR payload, captured on acceptance only
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr       <= '0;
      gnt       <= '0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      m_arburst <= '0;
      m_arprot  <= '0;
      m_arcache <= '0;
    end else if (accept) begin
      ptr       <= rr_idx(win_idx, 32'd1);
      gnt       <= win_idx;
      m_araddr  <= sel_addr;
      m_arlen   <= sel_len;
      m_arsize  <= sel_size;
      m_arburst <= sel_burst;
      m_arprot  <= sel_prot;
      m_arcache <= sel_cache;
    end
  end

  // Next state and handshake/R routing; s_arready is held low while reset is asserted
  always_comb begin
    state_nxt = state;
    s_arready = '0;
    s_rvalid  = '0;
    s_rdata   = '0;
    s_rresp   = '0;
    s_rlast   = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (aresetn && win_valid) s_arready[win_idx] = 1'b1;
        if (accept) state_nxt = reject ? ST_ERR : ST_ADDR;
      end
      ST_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        s_rvalid[gnt] = m_rvalid;
        m_rready      = s_rready[gnt];
        s_rdata       = m_rdata;
        s_rresp       = m_rresp;
        s_rlast       = m_rlast;
        if (m_rvalid && s_rready[gnt] && m_rlast) state_nxt = ST_IDLE;
      end
      ST_ERR: begin
`ifdef PIRADIP_AXI4_RD_ARB_4K_CHECK_EN
        s_rvalid[gnt] = 1'b1;
        s_rresp       = 2'b10;
        s_rlast       = (cnt == 8'd0);
        if (s_rready[gnt] && (cnt == 8'd0)) state_nxt = ST_IDLE;
`else
        state_nxt = ST_IDLE;
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign m_arlock   = 1'b0;
  assign m_arqos    = 4'd0;
  assign m_arregion = 4'd0;

endmodule
